// File: rtl/sdram_bridge_pkg.sv
// sdram_bridge_pkg: register offsets, CTRL/STATUS bit positions
// and FSM encoding for the SDRAM register bridge.
package sdram_bridge_pkg;

    localparam int OFF_CTRL  = 0;
    localparam int OFF_ALO   = 1;
    localparam int OFF_AHI   = 2;
    localparam int OFF_WDATA = 3;
    localparam int OFF_RDATA = 4;
    localparam int OFF_LEN   = 5;

    localparam int CTRL_START_WR = 0;
    localparam int CTRL_START_RD = 1;
    localparam int CTRL_FIFO_CLR = 2;
    localparam int CTRL_DONE_CLR = 3;
    localparam int CTRL_ERR_CLR  = 4;

    localparam int ST_BUSY  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_FULL  = 2;
    localparam int ST_DONE  = 3;
    localparam int ST_ERR   = 4;
    localparam int ST_TMO   = 5;
    localparam int ST_CNT   = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT
    } state_e;

endpackage

// File: rtl/sdram_rd_fifo.sv
// sdram_rd_fifo: synchronous read-data FIFO with count and clear.
// Clear wins over a same-cycle push or pop.
module sdram_rd_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [DW-1:0]            wdata,
    input  logic                     pop,
    output logic [DW-1:0]            rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // pointer and occupancy update
    always_comb begin
        do_push  = push && !full && !clr;
        do_pop   = pop && !empty && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop) count_d = count_q + 1'b1;
            if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/sdram_reg_bridge.sv
// sdram_reg_bridge: host register window driving SDRAM bursts.
// Optional wait abort: define SDRAM_BRIDGE_TIMEOUT_EN.
module sdram_reg_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int HOST_DW        = 16,
    parameter int REG_AW         = 5,
    parameter int SD_AW          = 24,
    parameter int SD_DW          = 8,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               host_cs_n,
    input  logic               host_we_n,
    input  logic               host_oe_n,
    input  logic [REG_AW-1:0]  host_addr,
    input  logic [HOST_DW-1:0] host_wdata,
    output logic [HOST_DW-1:0] host_rdata,
    output logic [SD_AW-1:0]   sd_addr,
    output logic [SD_DW-1:0]   sd_wr_data,
    output logic               sd_wr_enable,
    output logic               sd_rd_enable,
    input  logic [SD_DW-1:0]   sd_rd_data,
    input  logic               sd_rd_ready,
    input  logic               sd_busy,
    output logic               irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int HW = SD_AW - HOST_DW;

    function automatic logic hit(input logic [REG_AW-1:0] a, input int off);
        return a == REG_AW'(off);
    endfunction

    state_e             state_q, state_d;
    logic [HOST_DW-1:0] addr_lo_q, addr_lo_d;
    logic [HW-1:0]      addr_hi_q, addr_hi_d;
    logic [HOST_DW-1:0] wdata_q, wdata_d;
    logic [7:0]         len_q, len_d;
    logic [SD_AW-1:0]   wa_q, wa_d;
    logic [SD_DW-1:0]   wd_q, wd_d;
    logic [7:0]         beats_q, beats_d;
    logic               rd_op_q, rd_op_d;
    logic               rd_seen_q, rd_seen_d;
    logic               wr_en_q, wr_en_d;
    logic               rd_en_q, rd_en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               rd_prev_q, rd_prev_d;
    logic [HOST_DW-1:0] host_rdata_q, host_rdata_d;

    logic               host_wr, host_rd, ctrl_wr;
    logic               start_wr, start_rd, start_ok, start_bad;
    logic               rdata_rd, done_set, tmo_set;
    logic [HOST_DW-1:0] status;

    logic               fifo_push, fifo_pop, fifo_clr;
    logic               fifo_full, fifo_empty;
    logic [SD_DW-1:0]   fifo_rdata;
    logic [CW-1:0]      fifo_count;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
`endif

    sdram_rd_fifo #(
        .DW    (SD_DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (fifo_clr),
        .push  (fifo_push),
        .wdata (sd_rd_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign host_wr = !host_cs_n && !host_we_n && host_oe_n;
    assign host_rd = !host_cs_n && host_we_n && !host_oe_n;

    // host decode, register file, read mux and sticky bits
    always_comb begin
        ctrl_wr   = host_wr && hit(host_addr, OFF_CTRL);
        start_wr  = ctrl_wr && host_wdata[CTRL_START_WR];
        start_rd  = ctrl_wr && host_wdata[CTRL_START_RD];
        start_ok  = (start_wr ^ start_rd) && (state_q == S_IDLE);
        start_bad = (start_wr || start_rd) && !start_ok;
        fifo_clr  = ctrl_wr && host_wdata[CTRL_FIFO_CLR];
        rd_prev_d = host_rd && hit(host_addr, OFF_RDATA);
        rdata_rd  = rd_prev_d && !rd_prev_q;
        fifo_pop  = rdata_rd;

        addr_lo_d = addr_lo_q;
        addr_hi_d = addr_hi_q;
        wdata_d   = wdata_q;
        len_d     = len_q;
        if (host_wr && hit(host_addr, OFF_ALO))   addr_lo_d = host_wdata;
        if (host_wr && hit(host_addr, OFF_AHI))   addr_hi_d = host_wdata[HW-1:0];
        if (host_wr && hit(host_addr, OFF_WDATA)) wdata_d = host_wdata;
        if (host_wr && hit(host_addr, OFF_LEN))   len_d = host_wdata[7:0];

        status = '0;
        status[ST_BUSY]  = state_q != S_IDLE;
        status[ST_EMPTY] = fifo_empty;
        status[ST_FULL]  = fifo_full;
        status[ST_DONE]  = done_q;
        status[ST_ERR]   = err_q;
        status[ST_CNT +: CW] = fifo_count;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        status[ST_TMO]   = tmo_q;
`endif

        host_rdata_d = '0;
        if (host_rd) begin
            unique case (1'b1)
                hit(host_addr, OFF_CTRL):  host_rdata_d = status;
                hit(host_addr, OFF_ALO):   host_rdata_d = addr_lo_q;
                hit(host_addr, OFF_AHI):   host_rdata_d = HOST_DW'(addr_hi_q);
                hit(host_addr, OFF_WDATA): host_rdata_d = wdata_q;
                hit(host_addr, OFF_LEN):   host_rdata_d = HOST_DW'(len_q);
                hit(host_addr, OFF_RDATA): begin
                    if (rd_prev_q)        host_rdata_d = host_rdata_q;
                    else if (!fifo_empty) host_rdata_d = HOST_DW'(fifo_rdata);
                end
                default:                   host_rdata_d = '0;
            endcase
        end

        done_d = done_q;
        if (ctrl_wr && host_wdata[CTRL_DONE_CLR]) done_d = 1'b0;
        if (done_set) done_d = 1'b1;

        err_d = err_q;
        if (ctrl_wr && host_wdata[CTRL_ERR_CLR]) err_d = 1'b0;
        if (start_bad || (rdata_rd && fifo_empty) || tmo_set) err_d = 1'b1;

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        tmo_d = tmo_q;
        if (ctrl_wr && host_wdata[CTRL_ERR_CLR]) tmo_d = 1'b0;
        if (tmo_set) tmo_d = 1'b1;
`endif
    end

    // burst sequencer: next state, beat bookkeeping, enables
    always_comb begin
        state_d   = state_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        beats_d   = beats_q;
        rd_op_d   = rd_op_q;
        rd_seen_d = rd_seen_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        done_set  = 1'b0;
        tmo_set   = 1'b0;
        fifo_push = 1'b0;
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        cnt_d     = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    wa_d    = {addr_hi_q, addr_lo_q};
                    wd_d    = wdata_q[SD_DW-1:0];
                    beats_d = len_q;
                    rd_op_d = start_rd;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!sd_busy && !(rd_op_q && fifo_full)) begin
                    wr_en_d   = !rd_op_q;
                    rd_en_d   = rd_op_q;
                    rd_seen_d = 1'b0;
                    state_d   = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK, S_WAIT_DONE: begin
                if (rd_op_q && sd_rd_ready && !rd_seen_q) begin
                    fifo_push = 1'b1;
                    rd_seen_d = 1'b1;
                end
                if (state_q == S_WAIT_ACK) begin
                    if (sd_busy) state_d = S_WAIT_DONE;
                end else if (!sd_busy &&
                             (!rd_op_q || rd_seen_q || sd_rd_ready)) begin
                    state_d = S_NEXT;
                end
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
                if (state_d != S_NEXT &&
                    cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    tmo_set = 1'b1;
                    state_d = S_IDLE;
                end
`endif
            end
            S_NEXT: begin
                if (beats_q != '0) begin
                    beats_d = beats_q - 1'b1;
                    wa_d    = wa_q + 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_lo_q    <= '0;
            addr_hi_q    <= '0;
            wdata_q      <= '0;
            len_q        <= '0;
            wa_q         <= '0;
            wd_q         <= '0;
            beats_q      <= '0;
            rd_op_q      <= 1'b0;
            rd_seen_q    <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            rd_prev_q    <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            addr_hi_q    <= addr_hi_d;
            wdata_q      <= wdata_d;
            len_q        <= len_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            beats_q      <= beats_d;
            rd_op_q      <= rd_op_d;
            rd_seen_q    <= rd_seen_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rd_prev_q    <= rd_prev_d;
            host_rdata_q <= host_rdata_d;
        end
    end

`ifdef SDRAM_BRIDGE_TIMEOUT_EN
    // wait-time counter and timeout sticky bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end
`endif

    assign host_rdata   = host_rdata_q;
    assign sd_addr      = wa_q;
    assign sd_wr_data   = wd_q;
    assign sd_wr_enable = wr_en_q;
    assign sd_rd_enable = rd_en_q;
    assign irq          = done_q | err_q;

endmodule

// File: tb/tb_sdram_reg_bridge.sv
// tb_sdram_reg_bridge: directed tests for sdram_reg_bridge with a
// simple SDRAM controller responder.
module tb_sdram_reg_bridge;

    localparam logic [4:0] A_CTRL = 5'd0;
    localparam logic [4:0] A_ALO  = 5'd1;
    localparam logic [4:0] A_AHI  = 5'd2;
    localparam logic [4:0] A_WD   = 5'd3;
    localparam logic [4:0] A_RD   = 5'd4;
    localparam logic [4:0] A_LEN  = 5'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        host_cs_n = 1'b1;
    logic        host_we_n = 1'b1;
    logic        host_oe_n = 1'b1;
    logic [4:0]  host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic [15:0] host_rdata;
    logic [23:0] sd_addr;
    logic [7:0]  sd_wr_data;
    logic        sd_wr_enable, sd_rd_enable;
    logic [7:0]  sd_rd_data = '0;
    logic        sd_rd_ready = 1'b0;
    logic        sd_busy = 1'b0;
    logic        irq;

    int vec = 0;
    int bad = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    logic [23:0] la[$];
    logic [7:0]  ld[$];
    bit          hang = 1'b0;
    int          ph = 0;
    bit          is_rd = 1'b0;
    logic [23:0] cur_a = '0;

    always #5 clk = ~clk;

    sdram_reg_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .host_cs_n    (host_cs_n),
        .host_we_n    (host_we_n),
        .host_oe_n    (host_oe_n),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_rdata   (host_rdata),
        .sd_addr      (sd_addr),
        .sd_wr_data   (sd_wr_data),
        .sd_wr_enable (sd_wr_enable),
        .sd_rd_enable (sd_rd_enable),
        .sd_rd_data   (sd_rd_data),
        .sd_rd_ready  (sd_rd_ready),
        .sd_busy      (sd_busy),
        .irq          (irq)
    );

    // controller model: busy one cycle after a command, two cycles
    // long; read data (addr ^ 0x5A) with rd_ready as busy falls
    always @(negedge clk) begin
        if (!rst_n) begin
            ph = 0;
            sd_busy = 1'b0;
            sd_rd_ready = 1'b0;
        end else begin
            sd_rd_ready = 1'b0;
            if (sd_wr_enable) wr_cnt++;
            if (sd_rd_enable) rd_cnt++;
            if (sd_wr_enable || sd_rd_enable) begin
                la.push_back(sd_addr);
                ld.push_back(sd_wr_data);
            end
            if (ph == 0) begin
                if ((sd_wr_enable || sd_rd_enable) && !hang) begin
                    ph = 3;
                    is_rd = sd_rd_enable;
                    cur_a = sd_addr;
                end
            end else if (ph == 3) begin
                sd_busy = 1'b1;
                ph = 2;
            end else if (ph == 2) begin
                ph = 1;
            end else begin
                sd_busy = 1'b0;
                if (is_rd) begin
                    sd_rd_ready = 1'b1;
                    sd_rd_data = cur_a[7:0] ^ 8'h5A;
                end
                ph = 0;
            end
        end
    end

    task automatic hwrite(input logic [4:0] a, input logic [15:0] d);
        @(negedge clk);
        host_cs_n = 1'b0;
        host_we_n = 1'b0;
        host_oe_n = 1'b1;
        host_addr = a;
        host_wdata = d;
        @(negedge clk);
        host_cs_n = 1'b1;
        host_we_n = 1'b1;
    endtask

    task automatic hread(input logic [4:0] a, output logic [15:0] d);
        @(negedge clk);
        host_cs_n = 1'b0;
        host_we_n = 1'b1;
        host_oe_n = 1'b0;
        host_addr = a;
        @(negedge clk);
        d = host_rdata;
        host_cs_n = 1'b1;
        host_oe_n = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        logic [15:0] s;
        int n;
        n = 0;
        do begin
            hread(A_CTRL, s);
            n++;
        end while (s[0] && n < 500);
        vec++;
        if (s[0] !== 1'b0) begin
            bad++;
            $display("FAIL %s idle-wait status=%h want busy=0", nm, s);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] s;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vec++;
        if ({sd_wr_enable, sd_rd_enable, irq} !== 3'b000) begin
            bad++;
            $display("FAIL rst_outs got %b want 000",
                     {sd_wr_enable, sd_rd_enable, irq});
        end
        vec++;
        if (host_rdata !== 16'h0) begin
            bad++;
            $display("FAIL rst_rdata got %h want 0000", host_rdata);
        end
        rst_n = 1'b1;
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0002) begin
            bad++;
            $display("FAIL rst_status got %h want 0002", s);
        end
        hread(A_ALO, s);
        vec++;
        if (s !== 16'h0000) begin
            bad++;
            $display("FAIL rst_addr got %h want 0000", s);
        end
    endtask

    task automatic test_single_write();
        logic [15:0] s;
        int b, w0, r0;
        b = la.size();
        w0 = wr_cnt;
        r0 = rd_cnt;
        hwrite(A_ALO, 16'h0010);
        hwrite(A_AHI, 16'h0000);
        hwrite(A_LEN, 16'h0000);
        hwrite(A_WD, 16'h00A5);
        hwrite(A_CTRL, 16'h0001);
        wait_idle("wr1");
        vec++;
        if (wr_cnt - w0 !== 1 || rd_cnt - r0 !== 0) begin
            bad++;
            $display("FAIL wr1_pulses got wr=%0d rd=%0d want 1/0",
                     wr_cnt - w0, rd_cnt - r0);
        end
        vec++;
        if (la.size() <= b || la[b] !== 24'h000010 || ld[b] !== 8'hA5) begin
            bad++;
            $display("FAIL wr1_beat got a=%h d=%h want 000010/a5",
                     la[b], ld[b]);
        end
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h000A || irq !== 1'b1) begin
            bad++;
            $display("FAIL wr1_done got st=%h irq=%b want 000a/1", s, irq);
        end
        hwrite(A_CTRL, 16'h0008);
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0002 || irq !== 1'b0) begin
            bad++;
            $display("FAIL done_clr got st=%h irq=%b want 0002/0", s, irq);
        end
    endtask

    task automatic test_read_wrap();
        logic [15:0] s;
        logic [23:0] a;
        logic [7:0]  e;
        int b, r0;
        b = la.size();
        r0 = rd_cnt;
        hwrite(A_ALO, 16'hFFFE);
        hwrite(A_AHI, 16'h00FF);
        hwrite(A_LEN, 16'h0003);
        hwrite(A_CTRL, 16'h0002);
        wait_idle("rd4");
        vec++;
        if (rd_cnt - r0 !== 4) begin
            bad++;
            $display("FAIL rd4_pulses got %0d want 4", rd_cnt - r0);
        end
        for (int i = 0; i < 4; i++) begin
            a = 24'hFFFFFE + 24'(i);
            vec++;
            if (la.size() <= b + i || la[b+i] !== a) begin
                bad++;
                $display("FAIL rd4_addr%0d got %h want %h", i, la[b+i], a);
            end
        end
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0408) begin
            bad++;
            $display("FAIL rd4_status got %h want 0408", s);
        end
        @(negedge clk);
        host_cs_n = 1'b0;
        host_we_n = 1'b1;
        host_oe_n = 1'b0;
        host_addr = A_RD;
        @(negedge clk);
        s = host_rdata;
        repeat (2) @(negedge clk);
        host_cs_n = 1'b1;
        host_oe_n = 1'b1;
        vec++;
        if (s !== 16'h00A4) begin
            bad++;
            $display("FAIL pop_held got %h want 00a4", s);
        end
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0308) begin
            bad++;
            $display("FAIL pop_once got %h want 0308", s);
        end
        for (int i = 1; i < 4; i++) begin
            a = 24'hFFFFFE + 24'(i);
            e = a[7:0] ^ 8'h5A;
            hread(A_RD, s);
            vec++;
            if (s !== {8'h00, e}) begin
                bad++;
                $display("FAIL pop%0d got %h want %h", i, s, {8'h00, e});
            end
        end
        hread(A_RD, s);
        vec++;
        if (s !== 16'h0000) begin
            bad++;
            $display("FAIL pop_empty got %h want 0000", s);
        end
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h001A || irq !== 1'b1) begin
            bad++;
            $display("FAIL empty_err got st=%h irq=%b want 001a/1", s, irq);
        end
        hwrite(A_CTRL, 16'h0018);
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0002 || irq !== 1'b0) begin
            bad++;
            $display("FAIL rd_clr got st=%h irq=%b want 0002/0", s, irq);
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] s;
        logic [7:0]  e;
        int r0;
        r0 = rd_cnt;
        hwrite(A_ALO, 16'h0100);
        hwrite(A_AHI, 16'h0000);
        hwrite(A_LEN, 16'h000B);
        hwrite(A_CTRL, 16'h0002);
        repeat (150) @(negedge clk);
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0805 || rd_cnt - r0 !== 8) begin
            bad++;
            $display("FAIL full_stall got st=%h beats=%0d want 0805/8",
                     s, rd_cnt - r0);
        end
        for (int i = 0; i < 4; i++) begin
            e = 8'(i) ^ 8'h5A;
            hread(A_RD, s);
            vec++;
            if (s !== {8'h00, e}) begin
                bad++;
                $display("FAIL full_pop%0d got %h want %h", i, s, {8'h00, e});
            end
        end
        wait_idle("full");
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h080C || rd_cnt - r0 !== 12) begin
            bad++;
            $display("FAIL full_done got st=%h beats=%0d want 080c/12",
                     s, rd_cnt - r0);
        end
        hwrite(A_CTRL, 16'h0004);
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h000A) begin
            bad++;
            $display("FAIL fifo_clr got %h want 000a", s);
        end
        hwrite(A_CTRL, 16'h0008);
    endtask

    task automatic test_both_start();
        logic [15:0] s;
        int w0, r0;
        w0 = wr_cnt;
        r0 = rd_cnt;
        hwrite(A_CTRL, 16'h0003);
        repeat (10) @(negedge clk);
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0012 || irq !== 1'b1 ||
            wr_cnt !== w0 || rd_cnt !== r0) begin
            bad++;
            $display("FAIL both_start got st=%h irq=%b dwr=%0d drd=%0d want 0012/1/0/0",
                     s, irq, wr_cnt - w0, rd_cnt - r0);
        end
        hwrite(A_CTRL, 16'h0010);
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0002 || irq !== 1'b0) begin
            bad++;
            $display("FAIL err_clr got st=%h irq=%b want 0002/0", s, irq);
        end
    endtask

    task automatic test_busy_start();
        logic [15:0] s;
        int b, w0;
        b = la.size();
        w0 = wr_cnt;
        hwrite(A_ALO, 16'h0020);
        hwrite(A_AHI, 16'h0000);
        hwrite(A_WD, 16'h0077);
        hwrite(A_LEN, 16'h0003);
        hwrite(A_CTRL, 16'h0001);
        hwrite(A_WD, 16'h0033);
        hwrite(A_ALO, 16'h0099);
        hwrite(A_CTRL, 16'h0001);
        wait_idle("busy");
        vec++;
        if (wr_cnt - w0 !== 4) begin
            bad++;
            $display("FAIL busy_beats got %0d want 4", wr_cnt - w0);
        end
        for (int i = 0; i < 4; i++) begin
            vec++;
            if (la.size() <= b + i || la[b+i] !== 24'h20 + 24'(i) ||
                ld[b+i] !== 8'h77) begin
                bad++;
                $display("FAIL busy_beat%0d got a=%h d=%h want %h/77",
                         i, la[b+i], ld[b+i], 24'h20 + 24'(i));
            end
        end
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h001A) begin
            bad++;
            $display("FAIL busy_err got %h want 001a", s);
        end
        hread(A_WD, s);
        vec++;
        if (s !== 16'h0033) begin
            bad++;
            $display("FAIL wdata_rb got %h want 0033", s);
        end
        hwrite(A_CTRL, 16'h0018);
    endtask

    task automatic test_timeout();
        logic [15:0] s;
        int w0;
        w0 = wr_cnt;
        hang = 1'b1;
        hwrite(A_ALO, 16'h0040);
        hwrite(A_LEN, 16'h0000);
        hwrite(A_CTRL, 16'h0001);
        repeat (1100) @(negedge clk);
        hread(A_CTRL, s);
`ifdef SDRAM_BRIDGE_TIMEOUT_EN
        vec++;
        if (s !== 16'h0032) begin
            bad++;
            $display("FAIL timeout got %h want 0032", s);
        end
`else
        vec++;
        if (s !== 16'h0003) begin
            bad++;
            $display("FAIL no_timeout got %h want 0003", s);
        end
`endif
        vec++;
        if (wr_cnt - w0 !== 1) begin
            bad++;
            $display("FAIL tmo_pulses got %0d want 1", wr_cnt - w0);
        end
        hang = 1'b0;
        do_reset();
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] s;
        int w0, n;
        w0 = wr_cnt;
        hwrite(A_ALO, 16'h0200);
        hwrite(A_WD, 16'h005C);
        hwrite(A_LEN, 16'h0003);
        hwrite(A_CTRL, 16'h0001);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sd_busy !== 1'b1 && n < 100);
        vec++;
        if (sd_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_wait got busy=%b want 1", sd_busy);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vec++;
        if (sd_wr_enable !== 1'b0 || irq !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst got en=%b irq=%b want 0/0",
                     sd_wr_enable, irq);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        vec++;
        if (wr_cnt - w0 !== 1) begin
            bad++;
            $display("FAIL mid_beats got %0d want 1", wr_cnt - w0);
        end
        hread(A_CTRL, s);
        vec++;
        if (s !== 16'h0002) begin
            bad++;
            $display("FAIL mid_status got %h want 0002", s);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_wrap();
        test_fifo_full();
        test_both_start();
        test_busy_start();
        test_timeout();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/sdram_reg_bridge.md
SDRAM_REG_BRIDGE -- requirements
Module: sdram_reg_bridge

Interface
REQ-001 Parameter HOST_DW, 16, host register data width.
REQ-002 Parameter REG_AW, 5, host register word-address width.
REQ-003 Parameter SD_AW, 24, SDRAM controller word-address width.
REQ-004 Parameter SD_DW, 8, SDRAM controller data width (≤ HOST_DW).
REQ-005 Parameter FIFO_DEPTH, 8, read FIFO entries (power of two, ≥2).
REQ-006 Parameter TIMEOUT_CYCLES, 1024, controller-wait abort limit.
REQ-007 Ports: clk  in  1  single clock; rst_n  in  1  asynchronous active-low reset.
REQ-008 Host side: host_cs_n, host_we_n, host_oe_n  in  1 each  active-low strobes; host_addr  in  REG_AW; host_wdata  in  HOST_DW; host_rdata  out  HOST_DW.
REQ-009 Controller side: sd_addr  out  SD_AW; sd_wr_data  out  SD_DW; sd_wr_enable, sd_rd_enable  out  1; sd_rd_data  in  SD_DW; sd_rd_ready, sd_busy  in  1.
REQ-010 irq  out  1  level, high while DONE or ERR sticky bit set.

Function
REQ-011 Host write = cs_n=0, we_n=0, oe_n=1 sampled at clk; host read = cs_n=0, we_n=1, oe_n=0; host_rdata registered, 1-cycle latency, 0 when not reading.
REQ-012 Register map (word offsets): 0 CTRL(W)/STATUS(R), 1 ADDR_LO, 2 ADDR_HI, 3 WDATA, 4 RDATA, 5 LEN; others read 0, writes ignored.
REQ-013 CTRL write bits: 0 START_WR, 1 START_RD, 2 FIFO_CLR, 3 DONE_CLR, 4 ERR_CLR; all self-clearing pulses.
REQ-014 STATUS: 0 busy, 1 fifo_empty, 2 fifo_full, 3 DONE sticky, 4 ERR sticky, 5 timeout sticky, [15:8] fifo count.
REQ-015 Burst length = LEN[7:0]+1 beats (1..256); address increments by 1 per beat, wraps modulo 2^SD_AW.
REQ-016 FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT; START_* in IDLE → ISSUE, latching ADDR and LEN into working copies.
REQ-017 ISSUE: when sd_busy=0 pulse sd_wr_enable or sd_rd_enable exactly one cycle → WAIT_ACK; read ISSUE additionally stalls while FIFO full.
REQ-018 WAIT_ACK → WAIT_DONE on sd_busy=1; WAIT_DONE → NEXT on sd_busy=0 (reads also require sd_rd_ready seen).
REQ-019 Read data captured into FIFO on the cycle sd_rd_ready=1, zero-extended to HOST_DW.
REQ-020 NEXT: if beats remain → ISSUE with address+1; else set DONE → IDLE.
REQ-021 Write bursts drive WDATA[SD_DW-1:0] on every beat (fill).
REQ-022 START_WR and START_RD in same write, or any START while not IDLE: command ignored, ERR set.
REQ-023 RDATA read pops FIFO once per read access (first cycle only); pop when empty returns 0, sets ERR.
REQ-024 FIFO_CLR empties FIFO; same-cycle capture is discarded.
REQ-025 Register writes to ADDR/LEN/WDATA mid-burst affect only the next command.

Reset
REQ-026 rst_n low: FSM IDLE, all registers, FIFO pointers, sticky bits, sd_wr_enable, sd_rd_enable, host_rdata, irq = 0; asserting mid-burst aborts immediately without further enables.

Configuration
REQ-027 Macro SDRAM_BRIDGE_TIMEOUT_EN defined: counter in WAIT_ACK/WAIT_DONE; reaching TIMEOUT_CYCLES sets timeout and ERR, returns IDLE, burst abandoned.
REQ-028 Macro undefined: no counter, FSM waits indefinitely, STATUS bit 5 reads 0.

Structure
REQ-029 Shared package sdram_bridge_pkg: register offsets, CTRL/STATUS bit positions, FSM state encoding.
REQ-030 One sub-module sdram_rd_fifo (synchronous FIFO, count, full/empty, clear).

Verification
REQ-031 ADDR=0x000010, LEN=0, WDATA=0x00A5, START_WR → one sd_wr_enable pulse, sd_addr=0x10, sd_wr_data=0xA5, DONE=1, irq=1.
REQ-032 LEN=3, ADDR=0xFFFFFE, START_RD → sd_addr 0xFFFFFE, 0xFFFFFF, 0x000000, 0x000001; FIFO count 4; four RDATA pops return captured bytes in order.
REQ-033 FIFO_DEPTH=8, LEN=11 read, no pops → FSM stalls in ISSUE with fifo_full=1; after 4 pops completes, DONE=1.
REQ-034 CTRL=0x0003 → no enables, ERR=1; ERR_CLR → ERR=0, irq=0.
REQ-035 With SDRAM_BRIDGE_TIMEOUT_EN, sd_busy held low after issue for 1024 cycles → timeout=1, ERR=1, FSM IDLE.
REQ-036 rst_n pulsed low during WAIT_DONE of 4-beat write → no further sd_wr_enable, STATUS reads 0x0002.
